eep_gpio_bidir: RTL and testbench
=================================

Name: eep_gpio_bidir

Overview:
- Parametrised Avalon-MM bidirectional GPIO port; next generation of the single-bit bit-bang pin blocks used for EEPROM I2C SCL/SDA.
- Adds WIDTH pins with per-bit direction, input synchronisers, atomic set/clear writes, edge capture and a maskable interrupt.
- Sits between the Nios bus fabric and FPGA top-level inout pins.

Parameters:
WIDTH, 8, number of pins (1..32).
SYNC_STAGES, 2, input synchroniser depth (2..4).
EDGE_TYPE, 2, edge capture type: 0 rising, 1 falling, 2 any.
RESET_OUT, 0, reset value of data_out register (WIDTH bits).
RESET_DIR, 0, reset value of direction register (1 = output).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
address  input  3  register select
chipselect  input  1  Avalon slave select
write_n  input  1  write strobe, active-low
writedata  input  32  write data; bits [WIDTH-1:0] used
readdata  output  32  registered read data; upper bits zero
irq  output  1  interrupt request, active-high
bidir_port  inout  WIDTH  pins

Behaviour:
- One clock, asynchronous active-high reset.
- Write strobe: wr = chipselect & ~write_n.
- Register map:
  - 0 DATA: read returns synchronised pin value; write loads data_out.
  - 1 DIR: read/write direction register.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read returns captures; write 1 clears the bit, write 0 has no effect.
  - 4 OUTSET: write ORs writedata into data_out; reads 0.
  - 5 OUTCLR: write clears data_out bits where writedata=1; reads 0.
  - 6, 7: reserved; read 0, writes ignored.
- Pin drive, per bit i: bidir_port[i] = dir[i] ? data_out[i] : Z.
- Input path: SYNC_STAGES flop chain per bit, plus one "prev" flop for edge detect.
- Edge detect:
  - rising = sync & ~prev; falling = ~sync & prev; any = sync ^ prev, selected by EDGE_TYPE.
  - Detection runs regardless of direction, so driven pins capture their own edges.
- Edge capture is sticky: EDGECAP[i] sets on detect. A detect and a W1C on the same cycle: set wins.
- irq = |(EDGECAP & IRQMASK), combinational from registers. No extra latency beyond EDGECAP.
- Read path: readdata registered every clock from the address mux, independent of chipselect. Read latency is 1 cycle.
- Pin-to-DATA latency: a pin change appears in the DATA mux after SYNC_STAGES edges, and in readdata one edge later.
- Pin-to-EDGECAP latency: EDGECAP bit sets on the edge SYNC_STAGES+1 after the pin changes.
- Register write to pin: the new value is on bidir_port one edge after the write.
- Reset values, async, take effect immediately (also mid-operation):
  - readdata = 0
  - data_out = RESET_OUT
  - dir = RESET_DIR
  - IRQMASK = 0
  - EDGECAP = 0
  - synchronisers and prev = 0
  - irq = 0
  - Pins tri-state where RESET_DIR bit is 0.
- Edge detect after reset: the first detect after reset release is compared against 0. A pin held high through reset therefore triggers a rising/any capture SYNC_STAGES+1 edges after release. Software clears it.
- Width rule: writedata bits above WIDTH-1 ignored; readdata bits above WIDTH-1 are 0.

Optional Feature:
- Macro EEP_GPIO_OPEN_DRAIN_EN.
- When defined, pins are open-drain: bidir_port[i] = (dir[i] & ~data_out[i]) ? 0 : Z. An output bit writing 1 releases the line for the external pull-up. This is used for I2C so that SDA/SCL never drive high.
- When undefined, push-pull behaviour as in Behaviour.
- Register map and timing are unchanged either way.

Test Plan:
- Reset: assert reset mid-write with RESET_DIR=0, RESET_OUT=0 -> immediately all pins Z, irq=0, all registers read 0.
- Direction/output: write DIR=0xFF, then DATA=0xA5 -> pins show 0xA5 one clk later. Then OUTSET=0x0A -> pins 0xAF. Then OUTCLR=0x81 -> pins 0x2E.
- Input sync latency: DIR=0, drive pins 0x3C externally, read DATA -> readdata=0x3C no earlier than SYNC_STAGES+1 clks after the pin change. Upper 24 bits are 0.
- Edge capture/irq (EDGE_TYPE=0): IRQMASK=0x01, toggle pin0 0->1 -> EDGECAP=0x01 at edge SYNC_STAGES+1 and irq=1. Falling edge gives no new capture. Write EDGECAP=0x01 -> irq=0 next clk.
- Simultaneous set/clear: a rising edge on pin0 detected in the same cycle as a W1C of EDGECAP bit0 -> bit0 stays 1 and irq stays asserted.
- Open-drain (EEP_GPIO_OPEN_DRAIN_EN defined): DIR=0x01, DATA=0x00 -> pin0=0. DATA=0x01 -> pin0=Z, and readback follows the pull-up value 1.

Source files
------------

// File: rtl/eep_gpio_bidir.sv
// eep_gpio_bidir
// Avalon-MM bidirectional GPIO port for FPGA top-level inout pins.
// Each bit has its own direction. Inputs are synchronised, and the port
// provides atomic set/clear writes, sticky edge capture and a maskable
// interrupt.
// Optional build macro: EEP_GPIO_OPEN_DRAIN_EN
//   When defined, pins are open-drain. An output bit at 0 pulls the line
//   low, and an output bit at 1 releases it to the external pull-up.
//   When undefined, output bits drive push-pull.
// Register map:
//   0 DATA     read synchronised pins / write data_out
//   1 DIR      direction, 1 = output
//   2 IRQMASK  interrupt mask
//   3 EDGECAP  sticky edge captures, write 1 to clear
//   4 OUTSET   write ORs into data_out, reads 0
//   5 OUTCLR   write clears data_out bits, reads 0
//   6, 7       reserved, read 0
module eep_gpio_bidir #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] RESET_DIR   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] bidir_port
);

    localparam logic [2:0]       ADDR_DATA    = 3'd0;
    localparam logic [2:0]       ADDR_DIR     = 3'd1;
    localparam logic [2:0]       ADDR_IRQMASK = 3'd2;
    localparam logic [2:0]       ADDR_EDGECAP = 3'd3;
    localparam logic [2:0]       ADDR_OUTSET  = 3'd4;
    localparam logic [2:0]       ADDR_OUTCLR  = 3'd5;
    localparam logic [WIDTH-1:0] ZERO_W       = {WIDTH{1'b0}};

    // Select edge polarity from EDGE_TYPE. Any value other than 0 or 1
    // means "any edge".
    function automatic logic [WIDTH-1:0] edge_detect(
        input logic [WIDTH-1:0] cur_v,
        input logic [WIDTH-1:0] prv_v
    );
        logic [WIDTH-1:0] result_v;
        case (EDGE_TYPE)
            32'sd0:  result_v = cur_v & ~prv_v;
            32'sd1:  result_v = ~cur_v & prv_v;
            default: result_v = cur_v ^ prv_v;
        endcase
        return result_v;
    endfunction

    logic             wr_s;
    logic [WIDTH-1:0] wdata_s;
    logic             wdata_unused_s;
    logic [WIDTH-1:0] data_out_r;
    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] irq_mask_r;
    logic [WIDTH-1:0] edge_cap_r;
    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] cap_clr_s;
    logic [31:0]      rd_mux_s;

    assign wr_s           = chipselect & ~write_n;
    assign wdata_s        = writedata[WIDTH-1:0];
    // The bits of writedata above WIDTH-1 are ignored on purpose.
    assign wdata_unused_s = ^writedata;
    assign sync_s         = sync_r[SYNC_STAGES-1];
    assign edge_s         = edge_detect(sync_s, prev_r);

    // Register writes: DATA, DIR and IRQMASK, plus atomic set/clear of data_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_r <= RESET_OUT;
            dir_r      <= RESET_DIR;
            irq_mask_r <= ZERO_W;
        end else if (wr_s) begin
            case (address)
                ADDR_DATA:    data_out_r <= wdata_s;
                ADDR_DIR:     dir_r      <= wdata_s;
                ADDR_IRQMASK: irq_mask_r <= wdata_s;
                ADDR_OUTSET:  data_out_r <= data_out_r | wdata_s;
                ADDR_OUTCLR:  data_out_r <= data_out_r & ~wdata_s;
                default:      data_out_r <= data_out_r;
            endcase
        end
    end

    // Input synchroniser chain, plus a prev stage used for edge detection.
    // After reset, prev starts at 0, so a pin held high through reset
    // shows up as a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= ZERO_W;
            end
            prev_r <= ZERO_W;
        end else begin
            sync_r[0] <= bidir_port;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
            prev_r <= sync_s;
        end
    end

    // Clear mask for EDGECAP, taken from a write-1-to-clear access.
    always_comb begin
        cap_clr_s = ZERO_W;
        if (wr_s && (address == ADDR_EDGECAP)) begin
            cap_clr_s = wdata_s;
        end else begin
            cap_clr_s = ZERO_W;
        end
    end

    // Sticky edge capture. The detect term is ORed in after the clear,
    // so a detect on the same cycle as a clear leaves the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap_r <= ZERO_W;
        end else begin
            edge_cap_r <= (edge_cap_r & ~cap_clr_s) | edge_s;
        end
    end

    // Read-data mux. Bits above WIDTH-1 stay zero.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (address)
            ADDR_DATA:    rd_mux_s[WIDTH-1:0] = sync_s;
            ADDR_DIR:     rd_mux_s[WIDTH-1:0] = dir_r;
            ADDR_IRQMASK: rd_mux_s[WIDTH-1:0] = irq_mask_r;
            ADDR_EDGECAP: rd_mux_s[WIDTH-1:0] = edge_cap_r;
            default:      rd_mux_s            = 32'h0000_0000;
        endcase
    end

    // Registered read data, updated every clock whether or not chipselect is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= 32'h0000_0000;
        end else begin
            readdata <= rd_mux_s;
        end
    end

    // Interrupt from register state only, with no latency beyond EDGECAP.
    always_comb begin
        irq = |(edge_cap_r & irq_mask_r);
    end

    // Per-pin drive: push-pull by default, open-drain when the macro is defined.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
`ifdef EEP_GPIO_OPEN_DRAIN_EN
        assign bidir_port[i] = (dir_r[i] & ~data_out_r[i]) ? 1'b0 : 1'bz;
`else
        assign bidir_port[i] = dir_r[i] ? data_out_r[i] : 1'bz;
`endif
    end

endmodule

// File: tb/tb_eep_gpio_bidir.sv
// tb_eep_gpio_bidir
// Directed scenarios plus a randomised run of eep_gpio_bidir, checked
// against a sample-history reference model.
`timescale 1ns/1ps
module tb_eep_gpio_bidir;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int ET = 0;
    localparam int HN = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    wire [W-1:0] pins;
    logic [W-1:0] tb_drv;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [W-1:0] m_out;
    logic [W-1:0] m_dir;
    logic [W-1:0] m_mask;
    logic [W-1:0] m_cap;
    logic [31:0]  m_rd;
    int           m_cnt;
    logic [W-1:0] m_smp [0:HN-1];
    logic         m_irq;

    assign m_irq = |(m_cap & m_mask);

    eep_gpio_bidir #(
        .WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(ET),
        .RESET_OUT(8'h00), .RESET_DIR(8'h00)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .bidir_port(pins)
    );

    // External driver: the bench drives every pin that the model says is an input.
    for (genvar i = 0; i < W; i++) begin : g_ext
        assign pins[i] = m_dir[i] ? 1'bz : tb_drv[i];
`ifdef EEP_GPIO_OPEN_DRAIN_EN
        pullup (pins[i]);
`endif
    end

    always #5 clk = ~clk;

    // Pin value sampled at clock edge idx since reset release; edges before release read 0.
    function automatic logic [W-1:0] smp_at(input int idx);
        if (idx < 1) return 8'h00;
        return m_smp[idx % HN];
    endfunction

    function automatic logic [W-1:0] edges_of(input logic [W-1:0] now_v, input logic [W-1:0] was_v);
        if (ET == 0) return now_v & ~was_v;
        else if (ET == 1) return ~now_v & was_v;
        else return now_v ^ was_v;
    endfunction

    // Model: a pin value seen at edge m reaches DATA S edges later.
    // EDGECAP sets one edge after the detect.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_out <= 8'h00; m_dir <= 8'h00; m_mask <= 8'h00; m_cap <= 8'h00;
            m_rd <= 32'h0; m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
            m_smp[(m_cnt + 1) % HN] <= pins;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_out  <= writedata[W-1:0];
                    3'd1: m_dir  <= writedata[W-1:0];
                    3'd2: m_mask <= writedata[W-1:0];
                    3'd4: m_out  <= m_out | writedata[W-1:0];
                    3'd5: m_out  <= m_out & ~writedata[W-1:0];
                    default: ;
                endcase
            end
            m_cap <= (m_cap & ~((chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : 8'h00))
                     | edges_of(smp_at(m_cnt + 1 - S), smp_at(m_cnt - S));
            case (address)
                3'd0: m_rd <= {24'h0, smp_at(m_cnt + 1 - S)};
                3'd1: m_rd <= {24'h0, m_dir};
                3'd2: m_rd <= {24'h0, m_mask};
                3'd3: m_rd <= {24'h0, m_cap};
                default: m_rd <= 32'h0;
            endcase
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        d = readdata; chipselect = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        tb_drv = 8'h00;
        bus_write(3'd2, 32'h0000_00FF);
        bus_write(3'd1, 32'h0000_000F);
        bus_write(3'd0, 32'h0000_0005);
        bus_read(3'd1, d);
        checks++; if (d !== 32'h0000_000F) begin errors++; $display("FAIL reset_pre_dir got=%h exp=%h", d, 32'h0000_000F); end
        repeat (2) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL reset_pre_irq got=%b exp=1", irq); end
        @(negedge clk);
        address = 3'd0; writedata = 32'h0000_0055; chipselect = 1'b1; write_n = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (pins !== 8'h00) begin errors++; $display("FAIL reset_pins_released got=%h exp=00", pins); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(a[2:0], d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", a, d); end
        end
    endtask

    task automatic test_dir_out;
        logic [31:0] d;
        bus_write(3'd1, 32'h0000_00FF);
        bus_write(3'd0, 32'hFFFF_FFA5);
        checks++; if (pins !== 8'hA5) begin errors++; $display("FAIL out_data got=%h exp=a5", pins); end
        bus_write(3'd4, 32'h0000_000A);
        checks++; if (pins !== 8'hAF) begin errors++; $display("FAIL out_set got=%h exp=af", pins); end
        bus_write(3'd5, 32'h0000_0081);
        checks++; if (pins !== 8'h2E) begin errors++; $display("FAIL out_clr got=%h exp=2e", pins); end
        repeat (3) @(negedge clk);
        bus_read(3'd0, d);
        checks++; if (d !== 32'h0000_002E) begin errors++; $display("FAIL out_readback got=%h exp=2e", d); end
        bus_read(3'd4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL outset_reads0 got=%h exp=0", d); end
        bus_read(3'd5, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL outclr_reads0 got=%h exp=0", d); end
    endtask

    task automatic test_input_sync;
        tb_drv = 8'h00;
        bus_write(3'd1, 32'h0);
        repeat (4) @(negedge clk);
        bus_write(3'd3, 32'h0000_00FF);
        address = 3'd0;
        @(negedge clk);
        tb_drv = 8'h3C;
        for (int k = 1; k <= S + 1; k++) begin
            @(negedge clk);
            if (k <= S) begin
                checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL sync_early edge%0d got=%h exp=0", k, readdata); end
            end else begin
                checks++; if (readdata !== 32'h0000_003C) begin errors++; $display("FAIL sync_data got=%h exp=3c", readdata); end
            end
        end
    endtask

    task automatic test_edge_irq;
        logic [31:0] d;
        bus_write(3'd3, 32'h0000_00FF);
        bus_write(3'd2, 32'h0000_0001);
        @(negedge clk);
        tb_drv = 8'h3D;
        for (int k = 1; k <= S + 1; k++) begin
            @(negedge clk);
            checks++;
            if (irq !== (k == S + 1)) begin errors++; $display("FAIL edge_irq edge%0d got=%b exp=%b", k, irq, (k == S + 1)); end
        end
        bus_read(3'd3, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL edge_cap got=%h exp=01", d); end
        bus_write(3'd3, 32'h0000_0001);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got=%b exp=0", irq); end
        tb_drv = 8'h3C;
        repeat (S + 2) @(negedge clk);
        bus_read(3'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL falling_nocap got=%h exp=0", d); end
    endtask

    task automatic test_simultaneous;
        logic [31:0] d;
        @(negedge clk);
        tb_drv = 8'h3D;
        repeat (S) @(negedge clk);
        address = 3'd3; writedata = 32'h0000_0001; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL simul_irq got=%b exp=1", irq); end
        bus_read(3'd3, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL simul_cap got=%h exp=01", d); end
        bus_write(3'd3, 32'h0000_0001);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL simul_clear got=%b exp=0", irq); end
    endtask

`ifdef EEP_GPIO_OPEN_DRAIN_EN
    task automatic test_open_drain;
        logic [31:0] d;
        bus_write(3'd1, 32'h0000_0001);
        bus_write(3'd0, 32'h0000_0000);
        checks++; if (pins[0] !== 1'b0) begin errors++; $display("FAIL od_low got=%b exp=0", pins[0]); end
        bus_write(3'd0, 32'h0000_0001);
        checks++; if (pins[0] !== 1'b1) begin errors++; $display("FAIL od_release got=%b exp=1", pins[0]); end
        repeat (3) @(negedge clk);
        bus_read(3'd0, d);
        checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL od_readback got=%b exp=1", d[0]); end
    endtask
`endif

    task automatic test_random;
        @(negedge clk);
        for (int n = 0; n < 600; n++) begin
            checks++; if (readdata !== m_rd) begin errors++; $display("FAIL rnd_readdata cyc%0d got=%h exp=%h", n, readdata, m_rd); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq cyc%0d got=%b exp=%b", n, irq, m_irq); end
            checks++; if ((pins & m_dir) !== (m_out & m_dir)) begin errors++; $display("FAIL rnd_pins cyc%0d got=%h exp=%h", n, pins & m_dir, m_out & m_dir); end
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom();
            if ($urandom_range(0, 3) == 0) tb_drv = 8'($urandom());
            reset = (n == 300) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; tb_drv = 8'h00;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_dir_out();
        test_input_sync();
        test_edge_irq();
        test_simultaneous();
`ifdef EEP_GPIO_OPEN_DRAIN_EN
        test_open_drain();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
